// File: rtl/comparator_pkg.sv
// Shared definitions for the magnitude comparators.
//   state_e : serial comparator FSM states (IDLE, SHIFT)
//   dec_e   : running decision of an MSB-first compare (UNDECIDED, LT, GT)
//   lge_t   : result flags {l, e, g}, the same one-hot layout the parallel
//             3-bit comparator drives, so both blocks compare bit-for-bit
//   dec_to_flags : final decision -> one-hot flags (UNDECIDED means equal)
package comparator_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    UNDECIDED = 2'd0,
    LT        = 2'd1,
    GT        = 2'd2
  } dec_e;

  typedef struct packed {
    logic l;
    logic e;
    logic g;
  } lge_t;

  localparam lge_t FLAGS_CLR = '0;

  function automatic lge_t dec_to_flags(input dec_e d);
    lge_t f;
    f = FLAGS_CLR;
    case (d)
      LT:      f.l = 1'b1;
      GT:      f.g = 1'b1;
      default: f.e = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// One bit step of an MSB-first unsigned compare.
//   dec_in  : decision from the more significant bits
//   a_bit   : current bit of operand A
//   b_bit   : current bit of operand B
//   dec_out : decision including this bit
// Purely combinational; cells can be chained for multi-bit-per-beat use.
module cmp_bit_cell
  import comparator_pkg::*;
(
  input  dec_e dec_in,
  input  logic a_bit,
  input  logic b_bit,
  output dec_e dec_out
);

  always_comb begin
    dec_out = dec_in;
    // The first differing bit from the MSB decides; later bits cannot override.
    if (dec_in == UNDECIDED && a_bit != b_bit)
      dec_out = a_bit ? GT : LT;
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB first.
//   clk, rst_n       : rising-edge clock, async active-low reset
//   start            : begin a compare (sampled only in IDLE)
//   bit_valid        : a_bit/b_bit carry a bit pair this cycle (SHIFT only)
//   a_bit, b_bit     : operand bits, MSB first
//   busy             : high while in SHIFT
//   done             : one-cycle pulse when L/E/G were just updated
//   L, E, G          : A<B, A==B, A>B; exactly one set after a compare,
//                      held until the next accepted start
module serial_magnitude_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic L,
  output logic E,
  output logic G
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  dec_e            dec_q, dec_d, dec_cell;
  lge_t            flags_q, flags_d;
  logic            done_q, done_d;

  cmp_bit_cell u_cell (
    .dec_in  (dec_q),
    .a_bit   (a_bit),
    .b_bit   (b_bit),
    .dec_out (dec_cell)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dec_q   <= UNDECIDED;
      flags_q <= FLAGS_CLR;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Bit inputs on the start cycle are not part of the operand.
        if (start) begin
          state_d = SHIFT;
          cnt_d   = CW'(WIDTH);
          dec_d   = UNDECIDED;
          flags_d = FLAGS_CLR;
        end
      end
      SHIFT: begin
        // No bit_valid: bubble, everything holds. start is ignored here.
        if (bit_valid) begin
          cnt_d = cnt_q - CW'(1);
          dec_d = dec_cell;
          if (cnt_q == CW'(1)) begin
            // Use the cell output so the last bit can still decide.
            flags_d = dec_to_flags(dec_cell);
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign L    = flags_q.l;
  assign E    = flags_q.e;
  assign G    = flags_q.g;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench: stimulus pushes {expected flags, expected done cycle};
// a negedge monitor pops and checks on every done pulse.
module tb_serial_magnitude_comparator;

  localparam int W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, bit_valid = 1'b0, a_bit = 1'b0, b_bit = 1'b0;
  logic busy, done, L, E, G;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [2:0] lge;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  localparam logic [2:0] LGE_L = 3'b100;
  localparam logic [2:0] LGE_E = 3'b010;
  localparam logic [2:0] LGE_G = 3'b001;

  serial_magnitude_comparator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .busy      (busy),
    .done      (done),
    .L         (L),
    .E         (E),
    .G         (G)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got LGE=%b with empty scoreboard (cycle %0d)", {L, E, G}, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({L, E, G} !== e.lge) begin
          bad++;
          $display("FAIL result: got LGE=%b expected %b (cycle %0d)", {L, E, G}, e.lge, cyc);
        end
        total++;
        if (cyc != e.cyc) begin
          bad++;
          $display("FAIL latency: done at cycle %0d expected %0d", cyc, e.cyc);
        end
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL busy_at_done: got %b expected 0", busy);
        end
      end
    end
  end

  // Entered just after a clock edge; returns just after the last-bit edge with
  // bit_valid low so the next call can raise start on the done cycle.
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int gap, input bit pulse, input logic [2:0] lge,
                         input bit deep);
    exp_t e;
    e.lge = lge;
    e.cyc = cyc + 1 + W + gap;
    sb.push_back(e);
    start = 1'b1;
    bit_valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      @(posedge clk); #1;
      if (deep) begin
        chk("busy_in_shift", {7'd0, busy}, 8'd1);
        if (i == W - 1) chk("flags_cleared", {5'd0, L, E, G}, 8'd0);
      end
      start = pulse;
      bit_valid = 1'b1;
      a_bit = a[i];
      b_bit = b[i];
      if (i == W - 1 && gap > 0) begin
        @(posedge clk); #1;
        bit_valid = 1'b0;
        a_bit = ~a_bit;
        b_bit = ~b_bit;
        repeat (gap - 1) begin @(posedge clk); #1; end
        // drive the bubble's last cycle then restore next bit in loop
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {3'd0, busy, done, L, E, G}, 8'd0);
    rst_n = 1'b1;
    idle(2);
    chk("idle_outputs", {3'd0, busy, done, L, E, G}, 8'd0);

    // bit_valid in IDLE is ignored
    bit_valid = 1'b1; a_bit = 1'b1;
    idle(2);
    chk("idle_ignores_bits", {6'd0, busy, done}, 8'd0);
    bit_valid = 1'b0; a_bit = 1'b0;

    // Directed vectors
    run_cmp(3'b000, 3'b000, 0, 1'b0, LGE_E, 1'b1);
    idle(2);
    chk("flags_hold_E", {5'd0, L, E, G}, {5'd0, LGE_E});
    run_cmp(3'b000, 3'b001, 0, 1'b0, LGE_L, 1'b1);
    idle(2);
    run_cmp(3'b100, 3'b000, 0, 1'b0, LGE_G, 1'b1);
    idle(2);
    // Bubbles and start pulses mid-stream
    run_cmp(3'b101, 3'b011, 2, 1'b1, LGE_G, 1'b0);
    idle(3);
    chk("no_restart_busy", {7'd0, busy}, 8'd0);

    // Abort with reset after two bits of 111 vs 000
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
    idle(2);
    bit_valid = 1'b0;
    chk("busy_before_abort", {7'd0, busy}, 8'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {3'd0, busy, done, L, E, G}, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);
    chk("after_abort", {3'd0, busy, done, L, E, G}, 8'd0);
    run_cmp(3'b001, 3'b001, 0, 1'b0, LGE_E, 1'b1);
    idle(2);

    // Back-to-back: second start on the done cycle
    run_cmp(3'b011, 3'b111, 0, 1'b0, LGE_L, 1'b1);
    run_cmp(3'b111, 3'b011, 0, 1'b0, LGE_G, 1'b1);

    // Exhaustive sweep, back-to-back
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        logic [2:0] x;
        x = (a < b) ? LGE_L : (a > b) ? LGE_G : LGE_E;
        run_cmp(W'(a), W'(b), 0, 1'b0, x, 1'b0);
      end
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 8'(sb.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
